// File: rtl/clause_scanner.sv
// clause_scanner
// Scans one clause at a time, literal by literal, against the current
// variable assignment. Emits a one-cycle summary strobe for the unit checker.
//
// Handshake: a literal transfers on a rising edge where lit_valid && lit_ready.
// lit_ready is a registered output and is high only in SCAN. lit_valid may
// drop at any time; a cycle without a transfer leaves all state unchanged.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   start                 begin a new clause (honoured only in IDLE)
//   lit_valid/lit_ready   literal handshake
//   lit_in                {negated, variable index}
//   lit_last              marks the final literal of the clause
//   asg_valid/asg_value   current assignment (bit i = variable i)
//   en_part_sat           one-cycle strobe, summary outputs valid
//   counter               falsified literal count (saturating)
//   clause_size           literal count minus one
//   part_sat              no true literal, at least one unassigned
//   conflict              every literal falsified
//   unit_lit              last unassigned literal of the clause
//   busy                  high in SCAN and DONE
//   dbg_state             current FSM state (0 IDLE, 1 SCAN, 2 DONE)
module clause_scanner #(
  parameter int size    = 8,
  parameter int var_num = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               lit_valid,
  output logic               lit_ready,
  input  logic [size-1:0]    lit_in,
  input  logic               lit_last,
  input  logic [var_num-1:0] asg_valid,
  input  logic [var_num-1:0] asg_value,
  output logic               en_part_sat,
  output logic [size-1:0]    counter,
  output logic [size-1:0]    clause_size,
  output logic               part_sat,
  output logic               conflict,
  output logic [size-1:0]    unit_lit,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int IW = (var_num > 1) ? $clog2(var_num) : 1;
  localparam logic [size-1:0] CNT_MAX = {size{1'b1}};
  localparam logic [size-1:0] ONE     = size'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [size-1:0] lit_cnt;
  logic [size-1:0] fals_cnt;
  logic [size-1:0] unit_q;
  logic            sat_q;
  logic            unas_q;

  // Literal classification
  logic [size-2:0] var_idx;
  logic [IW-1:0]   idx;
  logic            neg;
  logic            in_range;
  logic            lit_unas;
  logic            lit_true;
  logic            lit_false;
  logic            accept;

  // Running values including the literal on the bus this cycle
  logic [size-1:0] lit_cnt_nx;
  logic [size-1:0] fals_cnt_nx;
  logic [size-1:0] unit_nx;
  logic            sat_nx;
  logic            unas_nx;

  assign var_idx   = lit_in[size-2:0];
  assign neg       = lit_in[size-1];
  assign idx       = var_idx[IW-1:0];
  // Out-of-range indices never touch the assignment vectors.
  assign in_range  = (int'(var_idx) < var_num);
  assign lit_unas  = !in_range || !asg_valid[idx];
  assign lit_true  = !lit_unas && (asg_value[idx] ^ neg);
  assign lit_false = !lit_unas && !lit_true;
  assign accept    = lit_valid && lit_ready;

  always_comb begin
    lit_cnt_nx  = (lit_cnt == CNT_MAX) ? lit_cnt : lit_cnt + ONE;
    fals_cnt_nx = (lit_false && fals_cnt != CNT_MAX) ? fals_cnt + ONE : fals_cnt;
    sat_nx      = sat_q || lit_true;
    unas_nx     = unas_q || lit_unas;
    unit_nx     = lit_unas ? lit_in : unit_q;
  end

  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lit_cnt     <= '0;
      fals_cnt    <= '0;
      unit_q      <= '0;
      sat_q       <= 1'b0;
      unas_q      <= 1'b0;
      lit_ready   <= 1'b0;
      en_part_sat <= 1'b0;
      counter     <= '0;
      clause_size <= '0;
      part_sat    <= 1'b0;
      conflict    <= 1'b0;
      unit_lit    <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          en_part_sat <= 1'b0;
          if (start) begin
            state     <= SCAN;
            lit_cnt   <= '0;
            fals_cnt  <= '0;
            sat_q     <= 1'b0;
            unas_q    <= 1'b0;
            lit_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (accept) begin
            lit_cnt  <= lit_cnt_nx;
            fals_cnt <= fals_cnt_nx;
            sat_q    <= sat_nx;
            unas_q   <= unas_nx;
            unit_q   <= unit_nx;
            // Summary is registered on the accepting edge so it is valid
            // in the same cycle as the strobe.
            if (lit_last) begin
              state       <= DONE;
              lit_ready   <= 1'b0;
              en_part_sat <= 1'b1;
              counter     <= fals_cnt_nx;
              clause_size <= lit_cnt_nx - ONE;
              part_sat    <= !sat_nx && unas_nx;
              conflict    <= !sat_nx && !unas_nx;
              unit_lit    <= unit_nx;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          en_part_sat <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          lit_ready   <= 1'b0;
          en_part_sat <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_scanner.sv
// Directed testbench for clause_scanner.
module tb_clause_scanner;

  logic       clock;
  logic       reset;
  logic       start;
  logic       lit_valid;
  logic       lit_ready;
  logic [7:0] lit_in;
  logic       lit_last;
  logic [7:0] asg_valid;
  logic [7:0] asg_value;
  logic       en_part_sat;
  logic [7:0] counter;
  logic [7:0] clause_size;
  logic       part_sat;
  logic       conflict;
  logic [7:0] unit_lit;
  logic       busy;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_fail;

  clause_scanner #(.size(8), .var_num(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .lit_valid   (lit_valid),
    .lit_ready   (lit_ready),
    .lit_in      (lit_in),
    .lit_last    (lit_last),
    .asg_valid   (asg_valid),
    .asg_value   (asg_value),
    .en_part_sat (en_part_sat),
    .counter     (counter),
    .clause_size (clause_size),
    .part_sat    (part_sat),
    .conflict    (conflict),
    .unit_lit    (unit_lit),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one clause of n literals (lits packed, literal 0 in the low byte).
  // lit_valid drops for gap_len cycles before literal gap_at.
  // The strobe is checked exactly start + n + gap_len cycles after start.
  task automatic scan_clause(input string tag, input logic [31:0] lits, input int n,
                             input int gap_at, input int gap_len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".ready"}, lit_ready, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        lit_valid = 1'b0;
        lit_in    = 8'h7f;
        for (int g = 0; g < gap_len; g++) tick();
        check({tag, ".gap_hold"}, {en_part_sat, lit_ready, dbg_state}, {1'b0, 1'b1, 2'd1});
      end
      lit_valid = 1'b1;
      lit_in    = lits[i*8 +: 8];
      lit_last  = (i == n - 1);
      tick();
    end
    lit_valid = 1'b0;
    lit_last  = 1'b0;
    check({tag, ".strobe"}, en_part_sat, 1'b1);
    check({tag, ".busy_done"}, busy, 1'b1);
    tick();
    check({tag, ".strobe_off"}, {en_part_sat, busy}, 2'b00);
  endtask

  // Stimulus and checks
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    lit_valid = 1'b0;
    lit_in    = 8'h00;
    lit_last  = 1'b0;
    asg_valid = 8'h00;
    asg_value = 8'h00;
    tick();
    tick();
    check("reset.ctl", {lit_ready, en_part_sat, part_sat, conflict, busy}, 5'b0);
    check("reset.cnt", {counter, clause_size, unit_lit}, 24'h0);
    check("reset.state", dbg_state, 2'd0);
    reset = 1'b0;
    tick();

    // {x0, ~x1, x2}: x0=0, x1=1, x2 unassigned
    asg_valid = 8'b0000_0011;
    asg_value = 8'b0000_0010;
    scan_clause("t1", {8'h00, 8'h02, 8'h81, 8'h00}, 3, -1, 0);
    check("t1.counter", counter, 8'd2);
    check("t1.size", clause_size, 8'd2);
    check("t1.flags", {part_sat, conflict}, 2'b10);
    check("t1.unit", unit_lit, 8'h02);

    // Same clause with x2=0: conflict
    asg_valid = 8'b0000_0111;
    asg_value = 8'b0000_0010;
    scan_clause("t2", {8'h00, 8'h02, 8'h81, 8'h00}, 3, -1, 0);
    check("t2.counter", counter, 8'd3);
    check("t2.size", clause_size, 8'd2);
    check("t2.flags", {part_sat, conflict}, 2'b01);

    // {x0, x3}: x0=1 true first, x3 unassigned; both consumed
    asg_valid = 8'b0000_0001;
    asg_value = 8'b0000_0001;
    scan_clause("t3", {16'h0, 8'h03, 8'h00}, 2, -1, 0);
    check("t3.counter", counter, 8'd0);
    check("t3.size", clause_size, 8'd1);
    check("t3.flags", {part_sat, conflict}, 2'b00);
    check("t3.unit", unit_lit, 8'h03);

    // {x0, ~x1, x2, x3}: three false, x3 unassigned; no gap then 2-cycle gap
    asg_valid = 8'b0000_0111;
    asg_value = 8'b0000_0010;
    scan_clause("t4a", {8'h03, 8'h02, 8'h81, 8'h00}, 4, -1, 0);
    check("t4a.counter", counter, 8'd3);
    check("t4a.size", clause_size, 8'd3);
    check("t4a.flags", {part_sat, conflict}, 2'b10);
    check("t4a.unit", unit_lit, 8'h03);
    scan_clause("t4b", {8'h03, 8'h02, 8'h81, 8'h00}, 4, 2, 2);
    check("t4b.counter", counter, 8'd3);
    check("t4b.size", clause_size, 8'd3);
    check("t4b.flags", {part_sat, conflict}, 2'b10);
    check("t4b.unit", unit_lit, 8'h03);

    // Reset after 2 of 4 literals
    start = 1'b1;
    tick();
    start     = 1'b0;
    lit_valid = 1'b1;
    lit_in    = 8'h00;
    tick();
    lit_in = 8'h81;
    tick();
    lit_in = 8'h02;
    #2;
    reset = 1'b1;
    #1;
    check("t5.rst_ctl", {lit_ready, en_part_sat, part_sat, conflict, busy}, 5'b0);
    check("t5.rst_cnt", {counter, clause_size, unit_lit}, 24'h0);
    check("t5.rst_state", dbg_state, 2'd0);
    tick();
    reset     = 1'b0;
    lit_last  = 1'b1;
    // Literals offered in IDLE must not be consumed.
    tick();
    tick();
    check("t5.idle_offer", {en_part_sat, lit_ready, busy}, 3'b000);
    lit_valid = 1'b0;
    lit_last  = 1'b0;
    asg_valid = 8'b0000_0011;
    asg_value = 8'b0000_0010;
    scan_clause("t5", {8'h00, 8'h02, 8'h81, 8'h00}, 3, -1, 0);
    check("t5.counter", counter, 8'd2);
    check("t5.size", clause_size, 8'd2);
    check("t5.flags", {part_sat, conflict}, 2'b10);
    check("t5.unit", unit_lit, 8'h02);

    // Variable index 9 is out of range: unassigned, even with all bits assigned
    asg_valid = 8'hff;
    asg_value = 8'h00;
    scan_clause("t6", {24'h0, 8'h09}, 1, -1, 0);
    check("t6.counter", counter, 8'd0);
    check("t6.size", clause_size, 8'd0);
    check("t6.flags", {part_sat, conflict}, 2'b10);
    check("t6.unit", unit_lit, 8'h09);

    // Summary holds after the strobe
    tick();
    tick();
    check("t6.hold", {part_sat, clause_size, unit_lit}, {1'b1, 8'd0, 8'h09});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clause_scanner.md
# clause_scanner

Upstream stage of the hardware BCP unit-check path. Accepts one clause at a time as a stream of encoded literals and evaluates each literal against the current variable assignment. Produces per-clause summary values: falsified-literal count, clause size minus one, partially-satisfied flag, conflict flag and the last unassigned literal. These feed the unit checker, which flags a unit clause when `counter == clause_size` and `part_sat` is high, qualified by the `en_part_sat` strobe.

## Interface
Parameters:
- `size`, 8, width of literal encoding and of the count outputs.
- `var_num`, 8, number of variables in the assignment vectors.

Ports:
- `clock`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new clause; accepted only in IDLE.
- `lit_valid`  in  1  literal on `lit_in` is valid.
- `lit_ready`  out  1  scanner accepts a literal this cycle.
- `lit_in`  in  size  bit size-1 = negated flag; bits size-2:0 = variable index.
- `lit_last`  in  1  qualifies the final literal of the clause.
- `asg_valid`  in  var_num  bit i set = variable i assigned.
- `asg_value`  in  var_num  bit i = value of variable i when assigned.
- `en_part_sat`  out  1  one-cycle strobe; summary outputs valid.
- `counter`  out  size  number of falsified literals.
- `clause_size`  out  size  number of literals minus one.
- `part_sat`  out  1  no true literal and at least one unassigned literal.
- `conflict`  out  1  every literal falsified.
- `unit_lit`  out  size  encoding of the last unassigned literal accepted.
- `busy`  out  1  high in SCAN and DONE.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- FSM states are IDLE, SCAN and DONE.
- IDLE -> SCAN on `start`. On this transition, clear the internal literal count, falsified count, sat flag and unassigned-seen flag.
- In SCAN, `lit_ready` = 1. A literal is accepted when `lit_valid` && `lit_ready`.
- Literal classification, with v = index and n = negated flag:
  - If v >= var_num or `asg_valid[v]` = 0: unassigned.
  - Else if `asg_value[v]` ^ n = 1: true.
  - Else: false.
- Each accepted literal:
  - increments the literal count;
  - increments the falsified count if false;
  - sets the sat flag if true;
  - if unassigned, captures `lit_in` into the unit_lit register and sets the unassigned-seen flag.
- Both counts saturate at 2^size-1.
- A true literal does not stop the scan. Remaining literals are consumed until `lit_last`.
- SCAN -> DONE when the accepted literal has `lit_last` = 1.
- In DONE, register the summary outputs and raise `en_part_sat` for exactly one cycle:
  - `counter` = falsified count;
  - `clause_size` = literal count - 1;
  - `part_sat` = !sat && unassigned-seen;
  - `conflict` = !sat && !unassigned-seen.
- DONE -> IDLE unconditionally on the next edge.
- `start` outside IDLE is ignored. Literals offered while `lit_ready` = 0 are not consumed.
- Summary outputs hold their values until the next DONE.

## Timing
- Reset values: state IDLE; `lit_ready`, `en_part_sat`, `part_sat`, `conflict`, `busy` = 0; `counter`, `clause_size`, `unit_lit` = 0.
- `lit_ready` is 1 starting the cycle after `start` is sampled in IDLE.
- Assignment vectors are sampled combinationally in the same cycle the literal is accepted.
- Throughput is one literal per cycle.
- Latency: `en_part_sat` is high in the cycle after the `lit_last` literal is accepted. The summary outputs are valid in that same cycle.
- Minimum clause period is N+2 cycles for N literals (start, N literals, DONE).
- A new `start` is accepted no earlier than the cycle after DONE.
- Reset asserted mid-scan: the FSM returns to IDLE immediately, with no `en_part_sat` and partial counts discarded.
- `lit_valid` gaps in SCAN stall the scan with no state change.

## Test plan
- 3-literal clause {x0, ¬x1, x2}, x0=0, x1=1, x2 unassigned. Required: `en_part_sat` pulse, `counter`=2, `clause_size`=2, `part_sat`=1, `conflict`=0, `unit_lit`=x2 encoding (0x02).
- Same clause with x2=0. Required: `counter`=3, `clause_size`=2, `part_sat`=0, `conflict`=1.
- Clause {x0, x3} with x0=1 first and x3 unassigned. Required: both literals consumed, `part_sat`=0, `conflict`=0, `counter`=0.
- 4-literal clause with `lit_valid` dropped for 2 cycles mid-stream. Required: `en_part_sat` 7 cycles after `start` (1 + 4 + 2 gap cycles), with the same results as the no-gap run.
- `reset` pulsed after 2 of 4 literals. Required: outputs return to 0, no strobe. The next clause scans correctly from a clean count.
- Variable index 9 with var_num=8 as the single literal. Required: literal treated as unassigned, `part_sat`=1, `clause_size`=0, `counter`=0.
